uart_rx_int: RTL and testbench
==============================

Name: uart_rx_int

Overview:
- Serial UART receiver that sits directly upstream of mips_cpu.
- Deserialises 8N1 frames from the rx pin into a one-byte holding register, which drives the CPU's uart_read_byte.
- Raises the CPU's int0 line (int_req) when a byte is ready.
- Clears the request when the CPU pulses uart_read_end after consuming the byte (ISR done with it).

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); minimum legal value 4.
- CNT_W, 16, width of the bit-period counter; must satisfy CNT_W ≥ clog2(CLKS_PER_BIT).

Ports:
- clk  in  1  system clock, the same clock as mips_cpu.
- rst  in  1  reset, synchronous, active-low: when rst=0 at a clk rising edge, the block resets. One clock domain only.
- rx_in  in  1  asynchronous serial line; idles high.
- read_end  in  1  single-cycle ack from CPU (uart_read_end); byte consumed.
- rx_byte  out  8  holding register; connects to uart_read_byte.
- int_req  out  1  level interrupt request; connects to int0.
- overrun  out  1  set when a frame completes while int_req=1.
- frame_err  out  1  set when a stop bit is sampled low.

Behaviour:
- Reset (rst=0 at clk edge):
  - rx_byte=8'h00, int_req=0, overrun=0, frame_err=0.
  - Synchroniser flops = 1; FSM=IDLE; counters=0.
  - Reset mid-frame abandons the frame; the next frame is received cleanly.
- Input sync: rx_in passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s (2 cycles of latency).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - rx_s=0 → START, with cnt cleared.
- START:
  - At cnt=CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - rx_s=1 → false start, return to IDLE, no flags.
  - rx_s=0 → DATA, with cnt=0 and bit_idx=0.
- DATA:
  - Each time cnt reaches CLKS_PER_BIT-1 (mid bit), shift rx_s into shift[bit_idx], LSB first, and reset cnt.
  - After bit_idx=7 is sampled → STOP.
- STOP:
  - At mid stop bit, sample rx_s and go to IDLE on the next edge in all cases.
  - rx_s=1 and int_req=0 (after read_end is applied): rx_byte←shift, int_req←1, frame_err←0.
  - rx_s=1 and int_req=1 with no read_end that cycle: byte dropped, rx_byte unchanged, overrun←1.
  - rx_s=0: byte discarded, frame_err←1, int_req/rx_byte unchanged.
- Latency:
  - int_req rises on the clk edge after the mid-stop sample.
  - This is about 9.5 bit periods + 3 cycles after the start-bit falling edge on rx_in.
- read_end handling:
  - read_end=1 clears int_req and overrun on the next edge.
  - read_end while int_req=0 is ignored.
  - read_end does not clear frame_err.
- Simultaneous read_end and a good-stop load in the same cycle: the load wins. int_req stays 1, rx_byte takes the new byte, overrun is cleared (the old byte was consumed).
- Counter width: cnt is CNT_W bits and never exceeds CLKS_PER_BIT-1, so there is no wrap-around.
- bit_idx: 3 bits, saturating at 7.
- Back-to-back frames: a start edge is accepted in IDLE immediately after STOP, with no gap required.
- rx_byte is stable while int_req=1, except on the simultaneous case above.

Decomposition:
- Package uart_pkg:
  - Enum for the FSM states IDLE/START/DATA/STOP.
  - Localparams DATA_BITS=8 and HALF_BIT=CLKS_PER_BIT/2, as a function of CLKS_PER_BIT.
- Sub-module uart_rx_sync:
  - 2-flop synchroniser with reset value 1 and the same active-low synchronous rst.
  - Instantiated once.
- Everything else (FSM, counters, shifter, holding register, flags) lives in uart_rx_int.

Test Plan (CLKS_PER_BIT=8):
- Reset: hold rst=0 for 3 cycles with rx_in toggling → all outputs 0. Release and send 8'hA5 → rx_byte=8'hA5 and int_req=1 about 78 cycles after the start edge; overrun=0, frame_err=0.
- Ack: after the 8'hA5 receipt, pulse read_end for 1 cycle → int_req=0 on the next edge, rx_byte still 8'hA5. Then send 8'h3C → int_req=1, rx_byte=8'h3C.
- Overrun: send 8'h11, no ack, then send 8'h22 → rx_byte=8'h11, int_req=1, overrun=1. Pulse read_end → int_req=0, overrun=0.
- Framing/glitch:
  - Send 8'h55 with stop bit=0 → frame_err=1, int_req=0, rx_byte unchanged.
  - Then a 2-cycle low glitch on rx_in → no state change (false start).
  - Then a good 8'h0F → rx_byte=8'h0F, frame_err=0.
- Simultaneous: time read_end to land exactly on the mid-stop cycle of a second byte 8'h77 while int_req=1 holding 8'h66 → rx_byte=8'h77, int_req=1, overrun=0.
- Reset mid-frame: assert rst=0 during DATA bit 4 of 8'hFF → outputs 0. Release and send 8'h81 → rx_byte=8'h81, int_req=1, no frame_err.

Source files
------------

// File: rtl/uart_rx_int_pkg.sv
// Shared types and constants for the UART receiver slice.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Offset from a bit edge to its centre, used to qualify the start bit.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_int_if.sv
// Byte-level link between the serial receiver and the CPU.
interface uart_rx_int_if;
  import uart_pkg::*;

  logic                 rx_in;
  logic                 read_end;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 int_req;
  logic                 overrun;
  logic                 frame_err;

  // CPU / line side: drives the pin and the ack, consumes byte and flags.
  modport master (
    output rx_in, read_end,
    input  rx_byte, int_req, overrun, frame_err
  );

  // Receiver side.
  modport slave (
    input  rx_in, read_end,
    output rx_byte, int_req, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  // Two-stage capture; both stages reset to the line idle level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_int.sv
// 8N1 UART receiver with a one-byte holding register and a level interrupt
// that the CPU clears by pulsing read_end after consuming the byte.
module uart_rx_int
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_int_if.slave  bus
);
  localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 int_req_q, int_req_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx_in),
    .q_o (rx_s)
  );

  // State, counters and all output flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      int_req_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      int_req_q   <= int_req_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame sequencing; an ack is applied first so a same-cycle good stop
  // sees the holding register as free and its load takes priority.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    int_req_d   = int_req_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;

    if (bus.read_end && int_req_q) begin
      int_req_d = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (!int_req_d) begin
            rx_byte_d   = shift_q;
            int_req_d   = 1'b1;
            frame_err_d = 1'b0;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_byte   = rx_byte_q;
  assign bus.int_req   = int_req_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_int.sv
// Directed plus randomized bench for uart_rx_int with a frame-level model.
module tb_uart_rx_int;
  localparam int CPB = 8;
  // Edges from the captured start edge to the edge where int_req can rise:
  // two synchroniser flops, half a bit to the start centre, nine full bits.
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_byte;
  logic       m_int, m_ovr, m_ferr;
  logic       int_pre, int_post;

  uart_rx_int_if bus ();

  uart_rx_int #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rx_byte"},   32'(bus.rx_byte),   32'(m_byte));
    check({tag, ".int_req"},   32'(bus.int_req),   32'(m_int));
    check({tag, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
  endtask

  task automatic model_reset();
    m_byte = 8'h00; m_int = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // Single-cycle ack from the CPU side.
  task automatic ack_pulse();
    @(negedge clk); bus.read_end = 1'b1;
    @(negedge clk); bus.read_end = 1'b0;
    if (m_int) begin m_int = 1'b0; m_ovr = 1'b0; end
  endtask

  // Drives one frame; cycle c is the cycle before edge E0+c. Optionally acks
  // on the mid-stop edge or asserts reset at cycle abort_c.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit ack_mid, input int abort_c);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c == abort_c) begin
        rst = 1'b0; bus.rx_in = 1'b1; bus.read_end = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        break;
      end
      bus.rx_in    = bits[c / CPB];
      bus.read_end = ack_mid && (c == LAT);
      if (c == LAT)     int_pre  = bus.int_req;
      if (c == LAT + 1) int_post = bus.int_req;
    end
    @(negedge clk);
    bus.rx_in = 1'b1; bus.read_end = 1'b0;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Complete frame with model update and checks.
  task automatic run_frame(input string tag, input logic [7:0] b,
                           input logic stop_bit, input bit ack_mid);
    logic acked, old_int;
    old_int = m_int;
    acked = ack_mid && m_int;
    send_frame(b, stop_bit, ack_mid, -1);
    if (stop_bit) begin
      if (!m_int || acked) begin
        m_byte = b; m_int = 1'b1; m_ferr = 1'b0;
        if (acked) m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
      if (acked) begin m_int = 1'b0; m_ovr = 1'b0; end
    end
    check({tag, ".int_before_stop"}, 32'(int_pre),  32'(old_int));
    check({tag, ".int_after_stop"},  32'(int_post), 32'(m_int));
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;
    bus.rx_in = 1'b1;
    bus.read_end = 1'b0;
    model_reset();

    // Reset with the line toggling
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.rx_in = i[0];
    end
    @(negedge clk); bus.rx_in = 1'b1;
    check_outputs("reset");
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_outputs("idle_after_reset");

    run_frame("rx_A5", 8'hA5, 1'b1, 1'b0);

    // Ack clears int_req, byte held
    ack_pulse();
    check_outputs("ack_A5");
    run_frame("rx_3C", 8'h3C, 1'b1, 1'b0);
    ack_pulse();

    // Overrun
    run_frame("rx_11", 8'h11, 1'b1, 1'b0);
    run_frame("ovr_22", 8'h22, 1'b1, 1'b0);
    ack_pulse();
    check_outputs("ack_ovr");

    // Framing error, glitch, recovery
    run_frame("ferr_55", 8'h55, 1'b0, 1'b0);
    @(negedge clk); bus.rx_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_outputs("glitch");
    run_frame("rx_0F", 8'h0F, 1'b1, 1'b0);
    ack_pulse();
    // Ack while idle is ignored
    ack_pulse();
    check_outputs("ack_idle");

    // Ack landing on the mid-stop edge of a second byte
    run_frame("rx_66", 8'h66, 1'b1, 1'b0);
    run_frame("simul_77", 8'h77, 1'b1, 1'b1);
    ack_pulse();

    // Reset during data bit 4
    send_frame(8'hFF, 1'b1, 1'b0, 4 * CPB + 10);
    model_reset();
    check_outputs("reset_mid_frame");
    run_frame("rx_81", 8'h81, 1'b1, 1'b0);

    // Randomized frames, acks and stop bits
    for (int n = 0; n < 24; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      run_frame($sformatf("rand%0d", n), rb, rstop, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
